mem_arbiter: RTL

//  Shares one single-port unified memory between the fetch stage and the

---
 rtl/mem_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, data first.
// Each access runs a fixed MEM_LAT sequence and finishes with a one-cycle ready pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rdy,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rdy,
    input  logic              hlt,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_DM, RESP, HALTED} state_t;
    state_t     r_state;
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            if_rdata  <= '0;
            if_rdy    <= 1'b0;
            dm_rdata  <= '0;
            dm_rdy    <= 1'b0;
            halted    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            if_rdy <= 1'b0;
            dm_rdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hlt) begin
                        r_state <= HALTED;
                        halted  <= 1'b1;
                    end else if (dm_re | dm_we) begin
                        r_state   <= BUSY_DM;
                        r_cnt     <= 4'(MEM_LAT);
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        r_state  <= BUSY_IF;
                        r_cnt    <= 4'(MEM_LAT);
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    r_cnt <= r_cnt - 4'd1;
                    // read data is sampled on the last busy cycle so it lands with the ready pulse
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        if (r_state == BUSY_IF) begin
                            if_rdata <= mem_rdata;
                            if_rdy   <= 1'b1;
                        end else begin
                            dm_rdy <= 1'b1;
                            if (!mem_we) dm_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    r_state <= hlt ? HALTED : IDLE;
                    halted  <= hlt;
                end
                HALTED: r_state <= HALTED;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
